// File: rtl/array_arb_pkg.sv
// Shared state encoding and default parameters for the array arbiter.
package array_arb_pkg;

    localparam int unsigned DefNreq     = 4;
    localparam int unsigned DefDepth    = 32;
    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefMaxBurst = 4;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StLocked
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping to 0.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] ptr_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    valid_o
);

    localparam int unsigned PW = $clog2(NREQ);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr_i) + k) % NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/array_arbiter.sv
// Round-robin arbiter with burst locking in front of a shared register array.
// Grants are registered; the granted requester's access is performed in the grant cycle.
module array_arbiter
    import array_arb_pkg::*;
#(
    parameter int unsigned NREQ      = DefNreq,
    parameter int unsigned DEPTH     = DefDepth,
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned MAX_BURST = DefMaxBurst
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               lock,
    input  logic [NREQ-1:0]               we,
    input  logic [NREQ*$clog2(DEPTH)-1:0] addr,
    input  logic [NREQ*WIDTH-1:0]         wdata,
    output logic [NREQ-1:0]               gnt,
    output logic                          rvalid,
    output logic [WIDTH-1:0]              rdata,
    output logic [$clog2(NREQ)-1:0]       rid
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    localparam logic [AW:0]   DepthLim = (AW + 1)'(DEPTH);
    localparam logic [BW-1:0] BurstLim = BW'(MAX_BURST);

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(NREQ - 1)) ? '0 : p + 1'b1;
    endfunction

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              rvalid_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [IW-1:0]     rid_q;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              lock_exit;
    logic [IW-1:0]     arb_ptr;
    logic [NREQ-1:0]   pick_gnt;
    logic              pick_valid;
    logic [IW-1:0]     pick_idx;

    logic              acc_valid;
    logic              acc_we;
    logic [AW-1:0]     acc_addr;
    logic [WIDTH-1:0]  acc_wdata;
    logic              acc_inrange;

    // A lock ends when the owner lets go or has used up its burst allowance.
    assign lock_exit = (state_q == StLocked) &&
                       !(req[owner_q] && lock[owner_q] && (burst_q < BurstLim));
    assign arb_ptr   = lock_exit ? ptr_inc(owner_q) : ptr_q;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req_i  (req),
        .ptr_i  (arb_ptr),
        .gnt_o  (pick_gnt),
        .valid_o(pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        if ((state_q == StLocked) && !lock_exit) begin
            gnt_d   = gnt_q;
            burst_d = burst_q + 1'b1;
        end else begin
            ptr_d   = arb_ptr;
            burst_d = '0;
            if (pick_valid) begin
                gnt_d   = pick_gnt;
                owner_d = pick_idx;
                if (lock[pick_idx]) begin
                    state_d = StLocked;
                    burst_d = BW'(1);
                end else begin
                    state_d = StAccess;
                    ptr_d   = ptr_inc(pick_idx);
                end
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
        end
    end

    // The owner of the current grant drives the access, even if its req has dropped.
    always_comb begin
        acc_valid   = |gnt_q;
        acc_we      = we[owner_q];
        acc_addr    = addr[owner_q*AW +: AW];
        acc_wdata   = wdata[owner_q*WIDTH +: WIDTH];
        acc_inrange = {1'b0, acc_addr} < DepthLim;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= acc_valid && !acc_we;
            if (acc_valid && !acc_we) begin
                rdata_q <= acc_inrange ? mem_q[acc_addr] : '0;
                rid_q   <= owner_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (acc_valid && acc_we && acc_inrange) begin
            mem_q[acc_addr] <= acc_wdata;
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rid    = rid_q;

endmodule

// File: tb/tb_array_arbiter.sv
// Self-checking bench for array_arbiter against a behavioural arbitration/memory model.
module tb_array_arbiter;

    localparam int NREQ      = 4;
    localparam int DEPTH     = 24;  // non power of two so 24..31 are out-of-range addresses
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int AW        = $clog2(DEPTH);
    localparam int IW        = $clog2(NREQ);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req, lock, we;
    logic [NREQ*AW-1:0]   addr;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]      gnt;
    logic                 rvalid;
    logic [WIDTH-1:0]     rdata;
    logic [IW-1:0]        rid;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int               m_ptr, m_gnt, m_owner, m_burst, m_rid;
    bit               m_locked, m_rvalid, m_rknown;
    logic [WIDTH-1:0] m_rdata;
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_known [DEPTH];

    array_arbiter #(
        .NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .we(we), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .rid(rid)
    );

    always #5 clk = ~clk;

    function automatic logic [NREQ-1:0] exp_gnt();
        return (m_gnt < 0) ? '0 : NREQ'(1) << m_gnt;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_gnt = -1; m_owner = 0; m_burst = 0; m_rid = 0;
        m_locked = 0; m_rvalid = 0; m_rknown = 1; m_rdata = '0;
    endtask

    task automatic model_edge();
        int a, start, w;
        bit hold;
        m_rvalid = 0;
        if (m_gnt >= 0) begin
            a = int'(addr[m_gnt*AW +: AW]);
            if (we[m_gnt]) begin
                if (a < DEPTH) begin
                    m_mem[a]   = wdata[m_gnt*WIDTH +: WIDTH];
                    m_known[a] = 1;
                end
            end else begin
                m_rvalid = 1;
                m_rid    = m_gnt;
                m_rdata  = (a < DEPTH) ? m_mem[a] : '0;
                m_rknown = (a >= DEPTH) || m_known[a];
            end
        end
        hold  = 0;
        start = m_ptr;
        if (m_locked) begin
            if (req[m_owner] && lock[m_owner] && m_burst < MAX_BURST) begin
                hold = 1;
                m_burst++;
            end else begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % NREQ;
                start    = m_ptr;
            end
        end
        if (!hold) begin
            w = -1;
            for (int i = 0; i < NREQ; i++)
                if (w < 0 && req[(start + i) % NREQ]) w = (start + i) % NREQ;
            m_gnt = w;
            if (w >= 0) begin
                if (lock[w]) begin
                    m_locked = 1; m_owner = w; m_burst = 1;
                end else begin
                    m_ptr = (w + 1) % NREQ;
                end
            end
        end
    endtask

    task automatic step();
        if (rst_n) model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; lock = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        #1;
        model_reset();
        n_tests++; if (gnt !== '0) begin n_fail++; $display("FAIL reset_gnt: got %b want 0", gnt); end
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
        n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_tests++; if (rid !== '0) begin n_fail++; $display("FAIL reset_rid: got %0d want 0", rid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b0100;
        step();
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL first_arb: got %b want 0100", gnt); end
        req = '0;
        step();
        step();
    endtask

    task automatic test_fill();
        int r;
        clear_inputs();
        we = '1;
        for (int a = 0; a < DEPTH; a++) begin
            r = a % NREQ;
            req = NREQ'(1) << r;
            addr[r*AW +: AW] = AW'(a);
            wdata[r*WIDTH +: WIDTH] = WIDTH'($urandom);
            step();
            n_tests++;
            if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL fill_gnt a=%0d: got %b want %b", a, gnt, exp_gnt()); end
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_write_read();
        clear_inputs();
        req[0] = 1'b1; we[0] = 1'b1; addr[0 +: AW] = 5; wdata[0 +: WIDTH] = 8'hA5;
        step();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL wr_gnt: got %b want 0001", gnt); end
        req[0] = 1'b0;  // drops req during its grant; the write must still land
        step();
        n_tests++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL wr_release: got %b want 0000", gnt); end
        we[0] = 1'b0; req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        step();
        n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_valid: got %b want 1", rvalid); end
        n_tests++; if (rdata !== 8'hA5) begin n_fail++; $display("FAIL rd_data: got %h want a5", rdata); end
        n_tests++; if (rid !== 2'd0) begin n_fail++; $display("FAIL rd_rid: got %0d want 0", rid); end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] want;
        do_reset();
        req = '1;
        for (int k = 0; k < 8; k++) begin
            step();
            want = NREQ'(1) << (k % NREQ);
            n_tests++;
            if (gnt !== want) begin n_fail++; $display("FAIL fair k=%0d: got %b want %b", k, gnt, want); end
        end
        req = '0;
        step();
        step();
    endtask

    task automatic test_burst_cap();
        logic [NREQ-1:0] g [6];
        clear_inputs();
        req = 4'b0100; lock = 4'b0100;
        step();
        g[0] = gnt;
        req = 4'b0101;
        for (int k = 1; k < 6; k++) begin
            step();
            g[k] = gnt;
            n_tests++;
            if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL burst_model k=%0d: got %b want %b", k, gnt, exp_gnt()); end
        end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (g[k] !== 4'b0100) begin n_fail++; $display("FAIL burst_hold k=%0d: got %b want 0100", k, g[k]); end
        end
        n_tests++; if (g[4] !== 4'b0001) begin n_fail++; $display("FAIL burst_cap: got %b want 0001", g[4]); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_early_unlock();
        do_reset();
        req = 4'b1010; lock = 4'b0010;
        step();
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL unlock_g0: got %b want 0010", gnt); end
        step();
        n_tests++; if (gnt !== 4'b0010) begin n_fail++; $display("FAIL unlock_g1: got %b want 0010", gnt); end
        lock = '0;
        step();
        n_tests++; if (gnt !== 4'b1000) begin n_fail++; $display("FAIL unlock_move: got %b want 1000", gnt); end
        clear_inputs();
        step();
        step();
    endtask

    task automatic test_reset_mid_read();
        clear_inputs();
        req[2] = 1'b1; addr[2*AW +: AW] = 3;
        step();
        n_tests++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL mid_gnt: got %b want 0100", gnt); end
        rst_n = 1'b0;
        req   = '0;
        #1;
        model_reset();
        n_tests++; if (gnt !== '0) begin n_fail++; $display("FAIL mid_rst_gnt: got %b want 0", gnt); end
        @(posedge clk);
        #1;
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rvalid: got %b want 0", rvalid); end
        rst_n = 1'b1;
        step();
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_post_rvalid: got %b want 0", rvalid); end
        req = '1;
        step();
        n_tests++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr: got %b want 0001", gnt); end
        req = '0;
        step();
        step();
    endtask

    task automatic test_out_of_range();
        int r;
        clear_inputs();
        req[1] = 1'b1; we[1] = 1'b1; addr[1*AW +: AW] = 28; wdata[1*WIDTH +: WIDTH] = 8'h5C;
        step();
        req = '0;
        step();
        we = '0; req[1] = 1'b1;
        step();
        req = '0;
        step();
        n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL oor_rvalid: got %b want 1", rvalid); end
        n_tests++; if (rdata !== '0) begin n_fail++; $display("FAIL oor_rdata: got %h want 0", rdata); end
        n_tests++; if (rid !== 2'd1) begin n_fail++; $display("FAIL oor_rid: got %0d want 1", rid); end
        for (int a = 0; a <= DEPTH; a++) begin
            r = a % NREQ;
            req = (a < DEPTH) ? NREQ'(1) << r : '0;
            addr[r*AW +: AW] = AW'(a % DEPTH);
            step();
            if (m_rvalid && m_rknown) begin
                n_tests++;
                if (rvalid !== 1'b1 || rdata !== m_rdata) begin
                    n_fail++;
                    $display("FAIL oor_scan a=%0d: got v=%b d=%h want v=1 d=%h", a, rvalid, rdata, m_rdata);
                end
            end
        end
        step();
    endtask

    task automatic test_random();
        clear_inputs();
        for (int c = 0; c < 400; c++) begin
            req   = NREQ'($urandom);
            lock  = NREQ'($urandom & $urandom & $urandom);
            we    = NREQ'($urandom);
            addr  = (NREQ*AW)'($urandom);
            wdata = (NREQ*WIDTH)'($urandom);
            step();
            n_tests++;
            if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL rnd_gnt c=%0d: got %b want %b", c, gnt, exp_gnt()); end
            n_tests++;
            if (rvalid !== m_rvalid) begin n_fail++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, rvalid, m_rvalid); end
            if (m_rvalid && m_rknown) begin
                n_tests++;
                if (rdata !== m_rdata || rid !== IW'(m_rid)) begin
                    n_fail++;
                    $display("FAIL rnd_rdata c=%0d: got d=%h id=%0d want d=%h id=%0d", c, rdata, rid, m_rdata, m_rid);
                end
            end
        end
        clear_inputs();
        step();
        step();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        test_reset();
        test_fill();
        test_write_read();
        test_fairness();
        test_burst_cap();
        test_early_unlock();
        test_reset_mid_read();
        test_out_of_range();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
